// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared defaults, FSM state type and width helper for the Connect4 column tracker
package connect4_pkg;

  localparam int DEFAULT_NUM_COLS = 7;
  localparam int DEFAULT_NUM_ROWS = 6;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } fsm_state_t;

  // Bits needed to hold a fill count from 0 up to and including rows.
  function automatic int clog2_rows(input int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/onehot_n_decoder.sv
// rtl/onehot_n_decoder.sv - active-low one-hot select to {valid, index}; valid only when exactly one bit is low
module onehot_n_decoder #(
  parameter int NUM_COLS = 7,
  parameter int IW       = $clog2(NUM_COLS)
) (
  input  logic [NUM_COLS-1:0] sel_n,
  output logic                valid,
  output logic [IW-1:0]       index
);

  logic [NUM_COLS-1:0] sel;

  assign sel   = ~sel_n;
  // Non-zero and a power of two means exactly one column is selected.
  assign valid = (sel != '0) && ((sel & (sel - 1'b1)) == '0);

  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (sel[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/column_fill_tracker.sv
// rtl/column_fill_tracker.sv - per-column fill counter for Connect4 drops; optional one-level undo with UNDO_EN
module column_fill_tracker
  import connect4_pkg::*;
#(
  parameter  int NUM_COLS = DEFAULT_NUM_COLS,
  parameter  int NUM_ROWS = DEFAULT_NUM_ROWS,
  localparam int CW       = clog2_rows(NUM_ROWS),
  localparam int IW       = $clog2(NUM_COLS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_COLS-1:0]    col_sel_n,
  input  logic                   add,
`ifdef UNDO_EN
  input  logic                   undo,
`endif
  output logic [NUM_COLS*CW-1:0] count,
  output logic [NUM_COLS-1:0]    col_full,
  output logic                   board_full,
  output logic                   drop_valid,
  output logic [IW-1:0]          drop_col,
  output logic [CW-1:0]          drop_row,
  output logic                   reject
);

  fsm_state_t          state, state_next;
  logic                eval;
  logic                sel_valid;
  logic [IW-1:0]       sel_index;
  logic [CW-1:0]       sel_count;
  logic                accept;
  logic                refuse;
  logic [NUM_COLS-1:0] inc_en;
  logic [NUM_COLS-1:0] dec_en;

  onehot_n_decoder #(
    .NUM_COLS (NUM_COLS),
    .IW       (IW)
  ) u_decoder (
    .sel_n (col_sel_n),
    .valid (sel_valid),
    .index (sel_index)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The drop is judged only on the edge that leaves IDLE, so a held add counts once.
  always_comb begin
    state_next = state;
    eval       = 1'b0;
    case (state)
      IDLE: if (add) begin
        state_next = HOLD;
        eval       = 1'b1;
      end
      HOLD: if (!add) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sel_count = count[int'(sel_index)*CW +: CW];
  assign accept    = eval && sel_valid && (sel_count < CW'(NUM_ROWS));
  assign refuse    = eval && !accept;

  always_comb begin
    inc_en = '0;
    if (accept) inc_en[sel_index] = 1'b1;
  end

`ifdef UNDO_EN
  logic          undo_prev;
  logic          hist_valid;
  logic [IW-1:0] hist_col;
  logic          undo_fire;

  // An add arriving on the same edge takes priority, so undo requires add low.
  assign undo_fire = (state == IDLE) && !add && undo && !undo_prev && hist_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      undo_prev  <= 1'b0;
      hist_valid <= 1'b0;
      hist_col   <= '0;
    end else begin
      undo_prev <= undo;
      if (accept) begin
        hist_valid <= 1'b1;
        hist_col   <= sel_index;
      end else if (undo_fire) begin
        hist_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    dec_en = '0;
    if (undo_fire) dec_en[hist_col] = 1'b1;
  end
`else
  assign dec_en = '0;
`endif

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_col
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset)                           cnt <= '0;
      else if (inc_en[i])                  cnt <= cnt + 1'b1;
      else if (dec_en[i] && (cnt != '0))   cnt <= cnt - 1'b1;
    end

    assign count[i*CW +: CW] = cnt;
    assign col_full[i]       = (cnt == CW'(NUM_ROWS));
  end

  assign board_full = &col_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_valid <= 1'b0;
      reject     <= 1'b0;
      drop_col   <= '0;
      drop_row   <= '0;
    end else begin
      drop_valid <= accept;
      reject     <= refuse;
      if (accept) begin
        drop_col <= sel_index;
        drop_row <= sel_count;
      end
    end
  end

endmodule
